// File: rtl/truth_table_sweeper.sv
// Stimulus/capture stage for a 3-input gate: walks {in1,in2,in3} through 000..111,
// samples the gate output per combination, flags instability and scores the table.
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned STABLE_WIN    = 4,
  parameter logic [7:0]  EXPECTED      = 8'hCA
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       gate_out,
  output logic [2:0] stim,
  output logic       busy,
  output logic       done,
  output logic [7:0] truth_table,
  output logic [7:0] unstable,
  output logic       match
);

  localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);
  // First counter value whose sample is compared against the previous one;
  // equals SETTLE_CYCLES when STABLE_WIN==1, so no comparison ever fires.
  localparam logic [CW-1:0] WIN_LO = CW'(SETTLE_CYCLES - STABLE_WIN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      stim_q, stim_d;
  logic            prev_q, prev_d;
  logic [7:0]      truth_q, truth_d;
  logic [7:0]      unstable_q, unstable_d;
  logic            match_q, match_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    stim_d     = stim_q;
    prev_d     = gate_out;
    truth_d    = truth_q;
    unstable_d = unstable_q;
    match_d    = match_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          truth_d    = 8'h00;
          unstable_d = 8'h00;
          match_d    = 1'b0;
          cnt_d      = '0;
          stim_d     = 3'd0;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        // Bit (7-k) of each result word belongs to combination k; ~k == 7-k.
        if (cnt_q >= WIN_LO && gate_out != prev_q) begin
          unstable_d[~stim_q] = 1'b1;
        end
        if (cnt_q == CNT_LAST) begin
          truth_d[~stim_q] = gate_out;
          cnt_d            = '0;
          if (stim_q == 3'd7) begin
            stim_d  = 3'd0;
            match_d = (truth_d == EXPECTED) && (unstable_d == 8'h00);
            state_d = DONE;
          end else begin
            stim_d = stim_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort wins over everything, including a same-edge start.
    if (abort) begin
      state_d    = IDLE;
      cnt_d      = '0;
      stim_d     = 3'd0;
      truth_d    = 8'h00;
      unstable_d = 8'h00;
      match_d    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      stim_q     <= 3'd0;
      prev_q     <= 1'b0;
      truth_q    <= 8'h00;
      unstable_q <= 8'h00;
      match_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stim_q     <= stim_d;
      prev_q     <= prev_d;
      truth_q    <= truth_d;
      unstable_q <= unstable_d;
      match_q    <= match_d;
    end
  end

  assign stim        = stim_q;
  assign busy        = (state_q == HOLD);
  assign done        = (state_q == DONE);
  assign truth_table = truth_q;
  assign unstable    = unstable_q;
  assign match       = match_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (S=16/W=4 and S=2/W=2) each driving a
// behavioural gate with optional 3-cycle latency and single-cycle glitch injection.
module tb_truth_table_sweeper;

  logic clk;
  logic rst;

  logic       start_a, abort_a, gate_a, busy_a, done_a, match_a;
  logic [2:0] stim_a;
  logic [7:0] tt_a, un_a;
  logic       start_b, abort_b, gate_b, busy_b, done_b, match_b;
  logic [2:0] stim_b;
  logic [7:0] tt_b, un_b;

  logic [7:0] code_a, code_b;
  logic       lat_a, lat_b, glitch_a, glitch_b;
  logic [2:0] dly_a, dly_b;

  int tests_run;
  int tests_failed;

  truth_table_sweeper #(.SETTLE_CYCLES(16), .STABLE_WIN(4), .EXPECTED(8'hCA)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .gate_out(gate_a),
    .stim(stim_a), .busy(busy_a), .done(done_a), .truth_table(tt_a),
    .unstable(un_a), .match(match_a)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(2), .STABLE_WIN(2), .EXPECTED(8'hCA)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .gate_out(gate_b),
    .stim(stim_b), .busy(busy_b), .done(done_b), .truth_table(tt_b),
    .unstable(un_b), .match(match_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gate under drive: output bit (7-k) of the code for input k, optionally through
  // a 3-stage register delay, XORed with a glitch strobe.
  always @(posedge clk) begin
    dly_a <= {dly_a[1:0], code_a[~stim_a]};
    dly_b <= {dly_b[1:0], code_b[~stim_b]};
  end
  assign gate_a = (lat_a ? dly_a[2] : code_a[~stim_a]) ^ glitch_a;
  assign gate_b = (lat_b ? dly_b[2] : code_b[~stim_b]) ^ glitch_b;

  // Reference: value seen by the sweeper during cycle n after the start edge.
  function automatic logic gate_at(input logic [7:0] code, input int s, input int lat,
                                   input int ng, input int n);
    int m;
    int st;
    m  = n - lat;
    st = (m < 0) ? 0 : m / s;
    if (st > 7) st = 0;
    return code[7-st] ^ (n == ng);
  endfunction

  function automatic void ref_sweep(input logic [7:0] code, input int s, input int w,
                                    input int lat, input int ng,
                                    output logic [7:0] tt, output logic [7:0] un,
                                    output logic m);
    tt = 8'h00;
    un = 8'h00;
    for (int k = 0; k < 8; k++) begin
      tt[7-k] = gate_at(code, s, lat, ng, (k + 1) * s - 1);
      for (int c = s - w + 1; c <= s - 1; c++) begin
        if (gate_at(code, s, lat, ng, k * s + c) != gate_at(code, s, lat, ng, k * s + c - 1))
          un[7-k] = 1'b1;
      end
    end
    m = (tt == 8'hCA) && (un == 8'h00);
  endfunction

  task automatic drive(input int which, input logic st, input logic ab, input logic gl);
    if (which == 0) begin
      start_a = st; abort_a = ab; glitch_a = gl;
    end else begin
      start_b = st; abort_b = ab; glitch_b = gl;
    end
  endtask

  // Runs one sweep; observed cycle-level behaviour is summarised into the outputs.
  task automatic run_sweep(input int which, input logic [7:0] code, input logic lat,
                           input int ng, input int restart_n, input int abort_n,
                           output int done_n, output int done_cnt,
                           output int stim_err, output int busy_err);
    int   s;
    logic aborted;
    logic exp_busy;
    int   exp_st;
    s = (which == 0) ? 16 : 2;
    @(negedge clk);
    if (which == 0) begin code_a = code; lat_a = lat; end
    else            begin code_b = code; lat_b = lat; end
    repeat (5) @(negedge clk);
    drive(which, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive(which, 1'b0, 1'b0, 1'b0);
    done_n = -1; done_cnt = 0; stim_err = 0; busy_err = 0;
    for (int n = 0; n < 8 * s + 4; n++) begin
      if (n > 0) @(negedge clk);
      aborted  = (abort_n >= 0) && (n > abort_n);
      exp_busy = !aborted && (n < 8 * s);
      exp_st   = exp_busy ? n / s : 0;
      if (int'((which == 0) ? stim_a : stim_b) != exp_st) stim_err++;
      if (((which == 0) ? busy_a : busy_b) !== exp_busy) busy_err++;
      if ((which == 0) ? done_a : done_b) begin
        done_cnt++;
        if (done_n < 0) done_n = n;
      end
      drive(which, n == restart_n, n == abort_n, n == ng);
    end
    drive(which, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    tests_run++;
    if (stim_a !== 3'b000 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: stim=%b busy=%b done=%b, required 000/0/0", stim_a, busy_a, done_a);
    end
    tests_run++;
    if (tt_a !== 8'h00 || un_a !== 8'h00 || match_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_results: tt=%h un=%h match=%b, required 00/00/0", tt_a, un_a, match_a);
    end
    tests_run++;
    if (stim_b !== 3'b000 || busy_b !== 1'b0 || tt_b !== 8'h00 || match_b !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_b: stim=%b busy=%b tt=%h match=%b, required zeros", stim_b, busy_b, tt_b, match_b);
    end
  endtask

  // Full sweep scenario checked against the reference model.
  task automatic test_sweep(input string name, input int which, input logic [7:0] code,
                            input logic lat, input int ng, input int restart_n);
    int d_n, d_c, s_e, b_e, s, w;
    logic [7:0] e_tt, e_un, o_tt, o_un;
    logic e_m, o_m;
    s = (which == 0) ? 16 : 2;
    w = (which == 0) ? 4 : 2;
    run_sweep(which, code, lat, ng, restart_n, -1, d_n, d_c, s_e, b_e);
    ref_sweep(code, s, w, lat ? 3 : 0, ng, e_tt, e_un, e_m);
    o_tt = (which == 0) ? tt_a : tt_b;
    o_un = (which == 0) ? un_a : un_b;
    o_m  = (which == 0) ? match_a : match_b;
    tests_run++;
    if (d_n != 8 * s || d_c != 1) begin
      tests_failed++;
      $display("FAIL %s done_timing: first=%0d pulses=%0d, required %0d/1", name, d_n, d_c, 8 * s);
    end
    tests_run++;
    if (s_e != 0 || b_e != 0) begin
      tests_failed++;
      $display("FAIL %s stim_busy: stim_err=%0d busy_err=%0d, required 0/0", name, s_e, b_e);
    end
    tests_run++;
    if (o_tt !== e_tt) begin
      tests_failed++;
      $display("FAIL %s truth_table: got %h, required %h", name, o_tt, e_tt);
    end
    tests_run++;
    if (o_un !== e_un) begin
      tests_failed++;
      $display("FAIL %s unstable: got %h, required %h", name, o_un, e_un);
    end
    tests_run++;
    if (o_m !== e_m) begin
      tests_failed++;
      $display("FAIL %s match: got %b, required %b", name, o_m, e_m);
    end
  endtask

  task automatic test_ca;
    test_sweep("ca", 0, 8'hCA, 1'b0, -1, -1);
    tests_run++;
    if (tt_a !== 8'hCA || match_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL ca_const: tt=%h match=%b, required CA/1", tt_a, match_a);
    end
  endtask

  task automatic test_53;
    test_sweep("g53", 0, 8'h53, 1'b0, -1, -1);
  endtask

  task automatic test_glitch;
    test_sweep("glitch", 0, 8'hCA, 1'b0, 5 * 16 + 13, -1);
    tests_run++;
    if (un_a !== 8'h04 || tt_a !== 8'hCA || match_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch_const: un=%h tt=%h match=%b, required 04/CA/0", un_a, tt_a, match_a);
    end
  endtask

  task automatic test_restart_ignored;
    test_sweep("restart", 0, 8'hCA, 1'b0, -1, 30);
  endtask

  task automatic test_abort;
    int d_n, d_c, s_e, b_e;
    run_sweep(0, 8'hCA, 1'b0, -1, -1, 40, d_n, d_c, s_e, b_e);
    tests_run++;
    if (d_c != 0) begin
      tests_failed++;
      $display("FAIL abort_done: pulses=%0d, required 0", d_c);
    end
    tests_run++;
    if (s_e != 0 || b_e != 0) begin
      tests_failed++;
      $display("FAIL abort_idle: stim_err=%0d busy_err=%0d, required 0/0", s_e, b_e);
    end
    tests_run++;
    if (tt_a !== 8'h00 || un_a !== 8'h00 || match_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_clear: tt=%h un=%h match=%b, required 00/00/0", tt_a, un_a, match_a);
    end
  endtask

  task automatic test_reset_mid;
    int busy_seen, done_seen;
    @(negedge clk);
    code_a = 8'hCA; lat_a = 1'b0;
    repeat (5) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (50) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (stim_a !== 3'b000 || busy_a !== 1'b0 || done_a !== 1'b0 ||
        tt_a !== 8'h00 || un_a !== 8'h00 || match_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: stim=%b busy=%b done=%b tt=%h un=%h match=%b, required all zero",
               stim_a, busy_a, done_a, tt_a, un_a, match_a);
    end
    @(negedge clk);
    rst = 1'b0;
    busy_seen = 0; done_seen = 0;
    repeat (160) begin
      @(negedge clk);
      if (busy_a || stim_a != 3'b000) busy_seen++;
      if (done_a) done_seen++;
    end
    tests_run++;
    if (busy_seen != 0 || done_seen != 0) begin
      tests_failed++;
      $display("FAIL reset_no_resume: busy_cycles=%0d done_cycles=%0d, required 0/0", busy_seen, done_seen);
    end
  endtask

  task automatic test_latency;
    test_sweep("lat_s16", 0, 8'hCA, 1'b1, -1, -1);
    tests_run++;
    if (match_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL lat_s16_match: got %b, required 1", match_a);
    end
    test_sweep("lat_s2", 1, 8'hCA, 1'b1, -1, -1);
    tests_run++;
    if (tt_b === 8'hCA || match_b !== 1'b0) begin
      tests_failed++;
      $display("FAIL lat_s2_const: tt=%h match=%b, required tt!=CA and match 0", tt_b, match_b);
    end
  endtask

  task automatic test_random;
    int which, s, ng;
    logic [7:0] code;
    logic lat;
    for (int i = 0; i < 10; i++) begin
      which = int'($urandom_range(0, 1));
      s     = (which == 0) ? 16 : 2;
      code  = 8'($urandom);
      if (i == 0) code = 8'hCA;
      lat   = 1'($urandom_range(0, 1));
      ng    = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 8 * s - 1));
      test_sweep($sformatf("rand%0d", i), which, code, lat, ng, -1);
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    start_a = 0; abort_a = 0; glitch_a = 0; code_a = 8'h00; lat_a = 0;
    start_b = 0; abort_b = 0; glitch_b = 0; code_b = 8'h00; lat_b = 0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    test_reset;
    @(negedge clk);
    rst = 1'b0;
    test_ca;
    test_53;
    test_glitch;
    test_restart_ignored;
    test_abort;
    test_reset_mid;
    test_latency;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
